uart_cmd_rcvr: RTL and testbench
================================

// Module: uart_cmd_rcvr
// PURPOSE
//  DUT-side end of the remote command link. Receives 8N1 UART bytes on RX and
//  assembles byte pairs (high first) into a 16-bit command with a cmd_rdy flag
//  for the command processor. Serializes an 8-bit response (e.g. 0xA5 ack) on TX.
//  Sits between the top-level RX/TX pins and the command/response logic.
// PARAMETERS
//  BAUD_CYCLES   2604      clk cycles per UART bit (50 MHz / 19200 baud)
//  TIMEOUT_CLKS  1000000   max clks between high and low byte (used only with timeout macro)
// PORTS
//  clk          in   1   system clock, all logic on posedge
//  rst_n        in   1   asynchronous active-low reset
//  RX           in   1   serial in, idle high, asynchronous to clk
//  TX           out  1   serial out, idle high
//  cmd          out  16  last assembled command {high byte, low byte}
//  cmd_rdy      out  1   new command available; held until cleared
//  clr_cmd_rdy  in   1   single-cycle clear of cmd_rdy from consumer
//  resp         in   8   response byte, sampled on trmt
//  trmt         in   1   single-cycle request to transmit resp
//  tx_done      out  1   response frame finished; held until next accepted trmt
//  frm_err      out  1   single-cycle pulse: received byte had stop bit = 0
// BEHAVIOUR
//  Reset: TX=1, cmd=0, cmd_rdy=0, tx_done=0, frm_err=0, both FSMs idle, byte FSM in HIGH.
//  RX path:
//   - RX double-flopped (preset to 1) before any use; start = falling edge of synced RX.
//   - RX FSM IDLE->RECV: baud counter loads BAUD_CYCLES/2, then BAUD_CYCLES per bit.
//     Samples at mid-bit: start, 8 data LSB first, stop (10 samples).
//   - Mid-start sample = 1 -> false start, return to IDLE, no byte.
//   - Stop sample = 0 -> byte discarded, frm_err pulses 1 clk, byte FSM unchanged.
//   - Valid byte -> 1-clk internal rx_rdy, 1 clk after stop-bit sample.
//  Byte FSM (HIGH, LOW):
//   - HIGH + rx_rdy: latch high byte -> LOW.
//   - LOW + rx_rdy: cmd <= {high,low}, cmd_rdy <= 1 in the same edge -> HIGH.
//     Latency: cmd_rdy high 2 clks after stop-bit mid-sample.
//   - cmd_rdy cleared by clr_cmd_rdy or by a detected start bit while in HIGH.
//     Set in the same cycle as clear -> set wins.
//   - cmd holds its value until the next full pair; a lone high byte never alters cmd.
//  TX path:
//   - trmt in IDLE: load {1,resp,0}, tx_done <= 0, -> XMIT.
//     TX drives start bit on the next clk; each bit lasts BAUD_CYCLES clks.
//   - After the stop bit period: -> IDLE, tx_done <= 1.
//   - trmt while XMIT is ignored; no queueing.
//   - TX and RX run fully independently and may be active together.
//  Reset mid-frame: both FSMs return to idle immediately; partial bytes and the
//  pending high byte are lost; TX goes high asynchronously.
// CONFIGURATION
//  CMD_BYTE_TIMEOUT_EN defined:
//   - counter runs while the byte FSM is in LOW.
//   - reaching TIMEOUT_CLKS with no low byte -> drop high byte, return to HIGH, no cmd_rdy.
//   - counter clears on entering LOW.
//  CMD_BYTE_TIMEOUT_EN undefined:
//   - no counter; LOW waits indefinitely; TIMEOUT_CLKS unused.
// TESTING
//  1 Send bytes 0x43 then 0xF2 at BAUD_CYCLES -> cmd=16'h43F2, cmd_rdy=1 two clks after
//    the 2nd stop-bit sample; cmd_rdy stays 1 until clr_cmd_rdy pulses, then 0 next clk.
//  2 resp=8'hA5 with trmt pulse -> TX shows 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop),
//    each bit BAUD_CYCLES clks; tx_done=1 after 10*BAUD_CYCLES clks.
//    A second trmt mid-frame has no effect.
//  3 Byte 0x50 with stop bit forced 0, then 0x50,0x01 -> frm_err one pulse;
//    cmd=16'h5001 (bad byte did not shift pairing).
//  4 RX low glitch of BAUD_CYCLES/4 clks -> no byte, no frm_err, cmd_rdy unchanged.
//  5 With CMD_BYTE_TIMEOUT_EN and TIMEOUT_CLKS=5000: send 0x12, idle 6000 clks, send
//    0x34,0x56 -> cmd=16'h3456. Without the macro the same stimulus yields cmd=16'h1234.
//  6 Assert rst_n=0 mid-way through high byte 0x43, release, send 0x43,0xF2
//    -> TX=1 during reset; cmd_rdy=0; afterwards cmd=16'h43F2.

Source files
------------

// File: rtl/uart_cmd_rcvr.sv
// UART command receiver: 8N1 RX bytes paired (high first) into a 16-bit command, plus an 8-bit response transmitter.
// Optional feature: define CMD_BYTE_TIMEOUT_EN to drop a lone high byte after TIMEOUT_CLKS clocks in LOW.
//
//   state       | meaning
//   RX_IDLE     | waiting for a falling edge on synced RX
//   RX_RECV     | sampling start, 8 data, stop at mid-bit
//   BYTE_HIGH   | next valid byte is the command high byte
//   BYTE_LOW    | high byte held, next valid byte completes the command
//   TX_IDLE     | TX idle high, waiting for trmt
//   TX_XMIT     | shifting start, resp LSB first, stop
module uart_cmd_rcvr #(
  parameter int BAUD_CYCLES  = 2604,
  parameter int TIMEOUT_CLKS = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done,
  output logic        frm_err
);

  localparam int BW = $clog2(BAUD_CYCLES);
  localparam logic [BW-1:0] BAUD_LOAD = BW'(BAUD_CYCLES - 1);
  localparam logic [BW-1:0] HALF_LOAD = BW'(BAUD_CYCLES / 2 - 1);

  if (BAUD_CYCLES < 4 || TIMEOUT_CLKS < 1) begin : g_param_check
    $error("uart_cmd_rcvr: BAUD_CYCLES must be >= 4 and TIMEOUT_CLKS >= 1");
  end

  typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;
  typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;
  typedef enum logic {BYTE_HIGH, BYTE_LOW} byte_state_t;

  rx_state_t   rx_state, rx_next;
  tx_state_t   tx_state, tx_next;
  byte_state_t byte_state, byte_next;

  // ---------------- RX path ----------------
  logic          rx_meta, rx_sync, rx_prev;
  logic [BW-1:0] rx_baud;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_rdy;
  logic          rx_tc, rx_fall;
  logic          rx_start, start_ok, byte_ok, byte_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;
  assign rx_tc   = (rx_baud == '0);

  always_comb begin
    rx_next  = rx_state;
    rx_start = 1'b0;
    start_ok = 1'b0;
    byte_ok  = 1'b0;
    byte_bad = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_start = 1'b1;
          rx_next  = RX_RECV;
        end
      end
      RX_RECV: begin
        if (rx_tc) begin
          if (rx_bit == 4'd0) begin
            if (rx_sync) rx_next = RX_IDLE;   // false start
            else         start_ok = 1'b1;
          end else if (rx_bit == 4'd9) begin
            rx_next  = RX_IDLE;
            byte_ok  = rx_sync;
            byte_bad = ~rx_sync;
          end
        end
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_baud  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_rdy   <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      rx_state <= rx_next;
      rx_rdy   <= byte_ok;
      frm_err  <= byte_bad;
      if (rx_start) begin
        rx_baud <= HALF_LOAD;
        rx_bit  <= '0;
      end else if (rx_state == RX_RECV) begin
        if (rx_tc) begin
          rx_baud <= BAUD_LOAD;
          rx_bit  <= rx_bit + 4'd1;
          if (rx_bit >= 4'd1 && rx_bit <= 4'd8) rx_shift <= {rx_sync, rx_shift[7:1]};
        end else begin
          rx_baud <= rx_baud - 1'b1;
        end
      end
    end
  end

  // ---------------- byte pairing ----------------
  logic [7:0] high_byte;
  logic       latch_high, cmd_load, rdy_clr, to_tc;

`ifdef CMD_BYTE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  logic [TW-1:0] to_cnt;

  assign to_tc = (to_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      to_cnt <= '0;
    else if (latch_high)                             to_cnt <= TW'(TIMEOUT_CLKS - 1);
    else if (byte_state == BYTE_LOW && !to_tc)       to_cnt <= to_cnt - 1'b1;
  end
`else
  assign to_tc = 1'b0;
`endif

  assign rdy_clr = clr_cmd_rdy | (start_ok & (byte_state == BYTE_HIGH));

  always_comb begin
    byte_next  = byte_state;
    latch_high = 1'b0;
    cmd_load   = 1'b0;
    case (byte_state)
      BYTE_HIGH: begin
        if (rx_rdy) begin
          latch_high = 1'b1;
          byte_next  = BYTE_LOW;
        end
      end
      BYTE_LOW: begin
        if (rx_rdy) begin
          cmd_load  = 1'b1;
          byte_next = BYTE_HIGH;
        end else if (to_tc) begin
          byte_next = BYTE_HIGH;
        end
      end
      default: byte_next = BYTE_HIGH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_state <= BYTE_HIGH;
      high_byte  <= '0;
      cmd        <= '0;
      cmd_rdy    <= 1'b0;
    end else begin
      byte_state <= byte_next;
      if (latch_high) high_byte <= rx_shift;
      if (cmd_load)   cmd       <= {high_byte, rx_shift};
      // set beats a simultaneous clear
      if (cmd_load)     cmd_rdy <= 1'b1;
      else if (rdy_clr) cmd_rdy <= 1'b0;
    end
  end

  // ---------------- TX path ----------------
  logic [BW-1:0] tx_baud;
  logic [8:0]    tx_shift;
  logic [3:0]    tx_left;
  logic          tx_tc, tx_load, tx_shift_en, tx_end;

  assign tx_tc = (tx_baud == '0);

  always_comb begin
    tx_next     = tx_state;
    tx_load     = 1'b0;
    tx_shift_en = 1'b0;
    tx_end      = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (trmt) begin
          tx_load = 1'b1;
          tx_next = TX_XMIT;
        end
      end
      TX_XMIT: begin
        if (tx_tc) begin
          if (tx_left == 4'd0) begin
            tx_end  = 1'b1;
            tx_next = TX_IDLE;
          end else begin
            tx_shift_en = 1'b1;
          end
        end
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_baud  <= '0;
      tx_shift <= '1;
      tx_left  <= '0;
      TX       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_state <= tx_next;
      if (tx_load) begin
        TX       <= 1'b0;
        tx_shift <= {1'b1, resp};
        tx_left  <= 4'd9;
        tx_baud  <= BAUD_LOAD;
        tx_done  <= 1'b0;
      end else if (tx_shift_en) begin
        TX       <= tx_shift[0];
        tx_shift <= {1'b1, tx_shift[8:1]};
        tx_left  <= tx_left - 4'd1;
        tx_baud  <= BAUD_LOAD;
      end else if (tx_end) begin
        TX      <= 1'b1;
        tx_done <= 1'b1;
      end else if (tx_state == TX_XMIT) begin
        tx_baud <= tx_baud - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_rcvr.sv
// Self-checking bench for uart_cmd_rcvr: directed scenarios plus randomized byte/clear/glitch/response traffic.
// Expected values come from a byte-level pairing model; bit timing is derived from the UART frame definition.
module tb_uart_cmd_rcvr;

  localparam int B  = 16;
  localparam int TO = 5000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        clr_cmd_rdy = 1'b0;
  logic        trmt = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        TX, cmd_rdy, tx_done, frm_err;
  logic [15:0] cmd;

  always #5 clk = ~clk;

  uart_cmd_rcvr #(.BAUD_CYCLES(B), .TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .trmt(trmt), .tx_done(tx_done), .frm_err(frm_err)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // byte-level reference model
  logic [15:0] exp_cmd = 16'h0;
  bit          exp_rdy = 1'b0;
  bit          pend = 1'b0;
  logic [7:0]  hi = 8'h0;
  int          exp_frm = 0;

  function automatic void model_rx(input logic [7:0] b, input bit ok);
    if (!pend) exp_rdy = 1'b0;          // a real start bit while waiting for a high byte clears ready
    if (!ok) begin
      exp_frm++;
      return;
    end
    if (pend) begin
      exp_cmd = {hi, b};
      exp_rdy = 1'b1;
      pend    = 1'b0;
    end else begin
      hi   = b;
      pend = 1'b1;
    end
  endfunction

  function automatic void model_reset();
    exp_cmd = 16'h0;
    exp_rdy = 1'b0;
    pend    = 1'b0;
  endfunction

  // monitors
  int cyc = 0;
  int frm_seen = 0;
  int rise_cyc = 0;
  int stop_cyc = 0;
  bit rdy_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frm_err) frm_seen <= frm_seen + 1;
    if (cmd_rdy && !rdy_q) rise_cyc <= cyc;
    rdy_q <= cmd_rdy;
  end

  task automatic check_rx_state(input string tag);
    chk({tag, "_cmd"}, cmd, exp_cmd);
    chk({tag, "_cmd_rdy"}, cmd_rdy, exp_rdy);
    chk({tag, "_frm_cnt"}, frm_seen, exp_frm);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    logic [9:0] bits;
    bits = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      RX = bits[i];
      if (i == 9) stop_cyc = cyc;
      repeat (B - 1) @(negedge clk);
    end
    @(negedge clk);
    RX = 1'b1;
    repeat (2 * B) @(negedge clk);
    model_rx(b, stop_ok);
    check_rx_state($sformatf("rx_%02h", b));
  endtask

  task automatic glitch();
    @(negedge clk);
    RX = 1'b0;
    repeat (B / 4) @(negedge clk);
    RX = 1'b1;
    repeat (2 * B) @(negedge clk);
    check_rx_state("glitch");
  endtask

  task automatic clear_rdy();
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    exp_rdy = 1'b0;
    chk("clr_cmd_rdy", cmd_rdy, exp_rdy);
  endtask

  task automatic tx_frame(input logic [7:0] r, input bit retrig);
    logic [9:0] f;
    f = {1'b1, r, 1'b0};
    @(negedge clk);
    resp = r;
    trmt = 1'b1;
    @(negedge clk);
    trmt = 1'b0;
    for (int k = 0; k <= 10 * B; k++) begin
      if (k == 0) chk("tx_done_clr", tx_done, 1'b0);
      if (k < 10 * B && (k % B) == B / 2) chk($sformatf("tx_%02h_bit%0d", r, k / B), TX, f[k / B]);
      if (k == 10 * B - 1) chk("tx_done_early", tx_done, 1'b0);
      if (k == 10 * B) chk("tx_done", tx_done, 1'b1);
      if (retrig && k == 4 * B + 3) begin
        resp = ~r;
        trmt = 1'b1;
      end else begin
        trmt = 1'b0;
      end
      @(negedge clk);
    end
    chk("tx_idle_high", TX, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    logic [7:0] rb;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_TX", TX, 1'b1);
    chk("rst_cmd", cmd, 16'h0);
    chk("rst_cmd_rdy", cmd_rdy, 1'b0);
    chk("rst_tx_done", tx_done, 1'b0);
    chk("rst_frm_err", frm_err, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // pair 0x43,0xF2 with ready latency and hold/clear behaviour
    send_byte(8'h43, 1'b1);
    send_byte(8'hF2, 1'b1);
    chk("rdy_latency_window", ((rise_cyc - stop_cyc) >= B / 2 + 1) && ((rise_cyc - stop_cyc) <= B / 2 + 6), 1'b1);
    repeat (100) @(negedge clk);
    chk("cmd_rdy_held", cmd_rdy, exp_rdy);
    clear_rdy();

    // response 0xA5, then a frame with a mid-frame trmt that must be ignored
    tx_frame(8'hA5, 1'b0);
    tx_frame(8'h3C, 1'b1);

    // bad stop bit does not shift pairing
    send_byte(8'h50, 1'b0);
    send_byte(8'h50, 1'b1);
    send_byte(8'h01, 1'b1);

    // short low glitch is not a byte
    glitch();

    // lone high byte followed by a long gap
    send_byte(8'h12, 1'b1);
    repeat (6000) @(negedge clk);
`ifdef CMD_BYTE_TIMEOUT_EN
    pend = 1'b0;
`endif
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);

    // randomized traffic
    for (int it = 0; it < 14; it++) begin
      op = $urandom_range(0, 5);
      rb = 8'($urandom);
      case (op)
        0, 1: send_byte(rb, 1'b1);
        2:    send_byte(rb, 1'b0);
        3:    glitch();
        4:    clear_rdy();
        default: begin
          fork
            send_byte(rb, 1'b1);
            tx_frame(8'($urandom), 1'b0);
          join
        end
      endcase
    end

    // reset in the middle of a received byte and a transmitted frame
    @(negedge clk);
    resp = 8'h00;
    trmt = 1'b1;
    @(negedge clk);
    trmt = 1'b0;
    RX = 1'b0;
    repeat (B) @(negedge clk);
    RX = 1'b1;
    repeat (B + B / 2) @(negedge clk);
    chk("tx_low_before_rst", TX, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_TX", TX, 1'b1);
    chk("rst_mid_cmd_rdy", cmd_rdy, 1'b0);
    chk("rst_mid_tx_done", tx_done, 1'b0);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_rx_state("post_rst");
    send_byte(8'h43, 1'b1);
    send_byte(8'hF2, 1'b1);
    chk("post_rst_final_cmd", cmd, 16'h43F2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
